// File: rtl/axi4lite_axi4_conv.sv
// AXI4-Lite responder to AXI4 initiator bridge: each Lite transfer becomes one
// single-beat INCR burst with a fixed ID, one transaction outstanding at a time.
module axi4lite_axi4_conv #(
  parameter logic [3:0] AXI_ID             = 4'd0,
  parameter bit         ERR_ON_ID_MISMATCH = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inport_awvalid_i,
  output logic        inport_awready_o,
  input  logic [31:0] inport_awaddr_i,
  input  logic        inport_wvalid_i,
  output logic        inport_wready_o,
  input  logic [31:0] inport_wdata_i,
  input  logic [3:0]  inport_wstrb_i,
  output logic        inport_bvalid_o,
  input  logic        inport_bready_i,
  output logic [1:0]  inport_bresp_o,
  input  logic        inport_arvalid_i,
  output logic        inport_arready_o,
  input  logic [31:0] inport_araddr_i,
  output logic        inport_rvalid_o,
  input  logic        inport_rready_i,
  output logic [31:0] inport_rdata_o,
  output logic [1:0]  inport_rresp_o,
  output logic        outport_awvalid_o,
  input  logic        outport_awready_i,
  output logic [31:0] outport_awaddr_o,
  output logic [3:0]  outport_awid_o,
  output logic [7:0]  outport_awlen_o,
  output logic [1:0]  outport_awburst_o,
  output logic        outport_wvalid_o,
  input  logic        outport_wready_i,
  output logic [31:0] outport_wdata_o,
  output logic [3:0]  outport_wstrb_o,
  output logic        outport_wlast_o,
  input  logic        outport_bvalid_i,
  output logic        outport_bready_o,
  input  logic [1:0]  outport_bresp_i,
  input  logic [3:0]  outport_bid_i,
  output logic        outport_arvalid_o,
  input  logic        outport_arready_i,
  output logic [31:0] outport_araddr_o,
  output logic [3:0]  outport_arid_o,
  output logic [7:0]  outport_arlen_o,
  output logic [1:0]  outport_arburst_o,
  input  logic        outport_rvalid_i,
  output logic        outport_rready_o,
  input  logic [31:0] outport_rdata_i,
  input  logic [1:0]  outport_rresp_i,
  input  logic [3:0]  outport_rid_i,
  input  logic        outport_rlast_i
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, WR_DONE, RD_REQ, RD_RESP, RD_DONE
  } state_t;

  state_t      state_reg;
  logic        awvalid_reg, wvalid_reg, arvalid_reg;
  logic        bready_reg, rready_reg, bvalid_reg, rvalid_reg;
  logic [31:0] addr_reg, wdata_reg, rdata_reg;
  logic [3:0]  wstrb_reg;
  logic [1:0]  bresp_reg, rresp_reg;
  logic        rd_err_reg, rr_last_wr_reg;

  logic wr_cand, rd_cand, grant_wr, grant_rd;
  logic aw_left, w_left, b_err, beat_err;

  // Round-robin only matters when both a full write (AW+W) and a read are offered.
  assign wr_cand  = inport_awvalid_i && inport_wvalid_i;
  assign rd_cand  = inport_arvalid_i;
  assign grant_wr = (state_reg == IDLE) && wr_cand && (!rd_cand || !rr_last_wr_reg);
  assign grant_rd = (state_reg == IDLE) && rd_cand && (!wr_cand || rr_last_wr_reg);

  assign aw_left  = awvalid_reg && !outport_awready_i;
  assign w_left   = wvalid_reg && !outport_wready_i;
  assign b_err    = ERR_ON_ID_MISMATCH && (outport_bid_i != AXI_ID);
  assign beat_err = ERR_ON_ID_MISMATCH && ((outport_rid_i != AXI_ID) || !outport_rlast_i);

  assign inport_awready_o  = grant_wr;
  assign inport_wready_o   = grant_wr;
  assign inport_arready_o  = grant_rd;
  assign inport_bvalid_o   = bvalid_reg;
  assign inport_bresp_o    = bresp_reg;
  assign inport_rvalid_o   = rvalid_reg;
  assign inport_rdata_o    = rdata_reg;
  assign inport_rresp_o    = rresp_reg;

  assign outport_awvalid_o = awvalid_reg;
  assign outport_awaddr_o  = addr_reg;
  assign outport_awid_o    = AXI_ID;
  assign outport_awlen_o   = 8'd0;
  assign outport_awburst_o = 2'b01;
  assign outport_wvalid_o  = wvalid_reg;
  assign outport_wdata_o   = wdata_reg;
  assign outport_wstrb_o   = wstrb_reg;
  assign outport_wlast_o   = 1'b1;
  assign outport_bready_o  = bready_reg;
  assign outport_arvalid_o = arvalid_reg;
  assign outport_araddr_o  = addr_reg;
  assign outport_arid_o    = AXI_ID;
  assign outport_arlen_o   = 8'd0;
  assign outport_arburst_o = 2'b01;
  assign outport_rready_o  = rready_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= IDLE;
      awvalid_reg    <= 1'b0;
      wvalid_reg     <= 1'b0;
      arvalid_reg    <= 1'b0;
      bready_reg     <= 1'b0;
      rready_reg     <= 1'b0;
      bvalid_reg     <= 1'b0;
      rvalid_reg     <= 1'b0;
      addr_reg       <= 32'd0;
      wdata_reg      <= 32'd0;
      rdata_reg      <= 32'd0;
      wstrb_reg      <= 4'd0;
      bresp_reg      <= 2'd0;
      rresp_reg      <= 2'd0;
      rd_err_reg     <= 1'b0;
      rr_last_wr_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_wr) begin
            addr_reg       <= inport_awaddr_i;
            wdata_reg      <= inport_wdata_i;
            wstrb_reg      <= inport_wstrb_i;
            awvalid_reg    <= 1'b1;
            wvalid_reg     <= 1'b1;
            rr_last_wr_reg <= 1'b1;
            state_reg      <= WR_REQ;
          end else if (grant_rd) begin
            addr_reg       <= inport_araddr_i;
            arvalid_reg    <= 1'b1;
            rr_last_wr_reg <= 1'b0;
            state_reg      <= RD_REQ;
          end
        end
        WR_REQ: begin
          // AW and W retire independently; move on once neither is left.
          awvalid_reg <= aw_left;
          wvalid_reg  <= w_left;
          if (!aw_left && !w_left) begin
            bready_reg <= 1'b1;
            state_reg  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (outport_bvalid_i) begin
            bready_reg <= 1'b0;
            bresp_reg  <= b_err ? 2'b10 : outport_bresp_i;
            bvalid_reg <= 1'b1;
            state_reg  <= WR_DONE;
          end
        end
        WR_DONE: begin
          if (inport_bready_i) begin
            bvalid_reg <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        RD_REQ: begin
          if (outport_arready_i) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            rd_err_reg  <= 1'b0;
            state_reg   <= RD_RESP;
          end
        end
        RD_RESP: begin
          // Stray beats before RLAST are drained; the error flag stays sticky.
          if (outport_rvalid_i) begin
            rdata_reg <= outport_rdata_i;
            if (outport_rlast_i) begin
              rresp_reg  <= (rd_err_reg || beat_err) ? 2'b10 : outport_rresp_i;
              rd_err_reg <= 1'b0;
              rready_reg <= 1'b0;
              rvalid_reg <= 1'b1;
              state_reg  <= RD_DONE;
            end else begin
              rresp_reg  <= outport_rresp_i;
              rd_err_reg <= rd_err_reg || beat_err;
            end
          end
        end
        RD_DONE: begin
          if (inport_rready_i) begin
            rvalid_reg <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_axi4_conv.sv
// Scoreboard bench for axi4lite_axi4_conv: Lite master tasks, an AXI4 target model
// and a monitor that pops expected Lite responses as the bridge returns them.
module tb_axi4lite_axi4_conv;
  localparam logic [3:0] AXI_ID = 4'd0;
  localparam int TMO = 500;
  localparam byte G_W = 8'h57;
  localparam byte G_R = 8'h52;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic inport_awvalid_i, inport_awready_o, inport_wvalid_i, inport_wready_o;
  logic [31:0] inport_awaddr_i, inport_wdata_i, inport_araddr_i, inport_rdata_o;
  logic [3:0] inport_wstrb_i;
  logic inport_bvalid_o, inport_bready_i, inport_arvalid_i, inport_arready_o;
  logic inport_rvalid_o, inport_rready_i;
  logic [1:0] inport_bresp_o, inport_rresp_o;
  logic outport_awvalid_o, outport_awready_i, outport_wvalid_o, outport_wready_i, outport_wlast_o;
  logic [31:0] outport_awaddr_o, outport_wdata_o, outport_araddr_o, outport_rdata_i;
  logic [3:0] outport_awid_o, outport_wstrb_o, outport_bid_i, outport_arid_o, outport_rid_i;
  logic [7:0] outport_awlen_o, outport_arlen_o;
  logic [1:0] outport_awburst_o, outport_arburst_o, outport_bresp_i, outport_rresp_i;
  logic outport_bvalid_i, outport_bready_o, outport_arvalid_o, outport_arready_i;
  logic outport_rvalid_i, outport_rready_o, outport_rlast_i;

  axi4lite_axi4_conv #(.AXI_ID(AXI_ID), .ERR_ON_ID_MISMATCH(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .inport_awvalid_i(inport_awvalid_i), .inport_awready_o(inport_awready_o),
    .inport_awaddr_i(inport_awaddr_i),
    .inport_wvalid_i(inport_wvalid_i), .inport_wready_o(inport_wready_o),
    .inport_wdata_i(inport_wdata_i), .inport_wstrb_i(inport_wstrb_i),
    .inport_bvalid_o(inport_bvalid_o), .inport_bready_i(inport_bready_i),
    .inport_bresp_o(inport_bresp_o),
    .inport_arvalid_i(inport_arvalid_i), .inport_arready_o(inport_arready_o),
    .inport_araddr_i(inport_araddr_i),
    .inport_rvalid_o(inport_rvalid_o), .inport_rready_i(inport_rready_i),
    .inport_rdata_o(inport_rdata_o), .inport_rresp_o(inport_rresp_o),
    .outport_awvalid_o(outport_awvalid_o), .outport_awready_i(outport_awready_i),
    .outport_awaddr_o(outport_awaddr_o), .outport_awid_o(outport_awid_o),
    .outport_awlen_o(outport_awlen_o), .outport_awburst_o(outport_awburst_o),
    .outport_wvalid_o(outport_wvalid_o), .outport_wready_i(outport_wready_i),
    .outport_wdata_o(outport_wdata_o), .outport_wstrb_o(outport_wstrb_o),
    .outport_wlast_o(outport_wlast_o),
    .outport_bvalid_i(outport_bvalid_i), .outport_bready_o(outport_bready_o),
    .outport_bresp_i(outport_bresp_i), .outport_bid_i(outport_bid_i),
    .outport_arvalid_o(outport_arvalid_o), .outport_arready_i(outport_arready_i),
    .outport_araddr_o(outport_araddr_o), .outport_arid_o(outport_arid_o),
    .outport_arlen_o(outport_arlen_o), .outport_arburst_o(outport_arburst_o),
    .outport_rvalid_i(outport_rvalid_i), .outport_rready_o(outport_rready_o),
    .outport_rdata_i(outport_rdata_i), .outport_rresp_i(outport_rresp_i),
    .outport_rid_i(outport_rid_i), .outport_rlast_i(outport_rlast_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr; logic [31:0] data; logic [3:0] strb; logic [1:0] bresp;
    bit bad_id; int aw_dly; int w_dly;
  } wr_t;
  typedef struct {
    logic [31:0] addr; logic [31:0] data; logic [1:0] rresp; int n_pre; bit bad_id;
  } rd_t;

  wr_t tgt_w_q[$];
  rd_t tgt_r_q[$];
  logic [1:0]  exp_b_q[$];
  logic [33:0] exp_r_q[$];
  byte grant_log[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout after %0d cycles", name, TMO);
  endtask

  function automatic wr_t mk_wr(logic [31:0] a, logic [31:0] d, logic [3:0] s,
                                logic [1:0] br, bit bad, int awd, int wd);
    wr_t w;
    w.addr = a; w.data = d; w.strb = s; w.bresp = br; w.bad_id = bad;
    w.aw_dly = awd; w.w_dly = wd;
    return w;
  endfunction

  function automatic rd_t mk_rd(logic [31:0] a, logic [31:0] d, logic [1:0] rr, int npre, bit bad);
    rd_t r;
    r.addr = a; r.data = d; r.rresp = rr; r.n_pre = npre; r.bad_id = bad;
    return r;
  endfunction

  // Reference model: ID mismatch or any non-final beat turns the response into SLVERR.
  function automatic logic [1:0] ref_bresp(wr_t w);
    return w.bad_id ? 2'b10 : w.bresp;
  endfunction

  function automatic logic [33:0] ref_r(rd_t r);
    return {((r.bad_id || r.n_pre > 0) ? 2'b10 : r.rresp), r.data};
  endfunction

  // Lite master write: tasks start and end one timestep after a rising edge.
  task automatic do_write(input wr_t w, input int hold, input bit fast);
    int t;
    logic [1:0] eb;
    eb = ref_bresp(w);
    tgt_w_q.push_back(w);
    exp_b_q.push_back(eb);
    inport_awaddr_i = w.addr; inport_wdata_i = w.data; inport_wstrb_i = w.strb;
    inport_awvalid_i = 1'b1; inport_wvalid_i = 1'b1;
    t = 0;
    do begin @(negedge clk_i); t++; end while (!inport_awready_o && t < TMO);
    if (!inport_awready_o) timeout("wr_accept");
    else if (fast) check("wr_accept_latency", t, 1);
    @(posedge clk_i); #1;
    inport_awvalid_i = 1'b0; inport_wvalid_i = 1'b0;
    check("wr_in_out_1cyc", {outport_awvalid_o, outport_wvalid_o}, 2'b11);
    t = 0;
    do begin @(negedge clk_i); t++; end while (!inport_bvalid_o && t < TMO);
    if (!inport_bvalid_o) timeout("wr_bvalid");
    for (int i = 0; i < hold; i++) begin
      check("b_hold", {inport_bvalid_o, inport_bresp_o}, {1'b1, eb});
      @(negedge clk_i);
    end
    @(posedge clk_i); #1;
    inport_bready_i = 1'b1;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    inport_bready_i = 1'b0;
  endtask

  task automatic do_read(input rd_t r, input int hold, input bit fast);
    int t;
    logic [33:0] er;
    er = ref_r(r);
    tgt_r_q.push_back(r);
    exp_r_q.push_back(er);
    inport_araddr_i = r.addr;
    inport_arvalid_i = 1'b1;
    t = 0;
    do begin @(negedge clk_i); t++; end while (!inport_arready_o && t < TMO);
    if (!inport_arready_o) timeout("rd_accept");
    else if (fast) check("rd_accept_latency", t, 1);
    @(posedge clk_i); #1;
    inport_arvalid_i = 1'b0;
    check("rd_in_out_1cyc", outport_arvalid_o, 1'b1);
    t = 0;
    do begin @(negedge clk_i); t++; end while (!inport_rvalid_o && t < TMO);
    if (!inport_rvalid_o) timeout("rd_rvalid");
    for (int i = 0; i < hold; i++) begin
      check("r_hold", {inport_rvalid_o, inport_rresp_o, inport_rdata_o}, {1'b1, er});
      @(negedge clk_i);
    end
    @(posedge clk_i); #1;
    inport_rready_i = 1'b1;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    inport_rready_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    inport_awvalid_i = 1'b0; inport_wvalid_i = 1'b0; inport_arvalid_i = 1'b0;
    inport_bready_i = 1'b0; inport_rready_i = 1'b0;
    inport_awaddr_i = '0; inport_wdata_i = '0; inport_wstrb_i = '0; inport_araddr_i = '0;
    exp_b_q.delete(); exp_r_q.delete();
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_handshakes", {outport_awvalid_o, outport_wvalid_o, outport_arvalid_o,
          outport_bready_o, outport_rready_o, inport_bvalid_o, inport_rvalid_o,
          inport_awready_o, inport_wready_o, inport_arready_o}, 0);
    check("reset_regs", {outport_awaddr_o, inport_rdata_o}, 0);
    check("reset_resp", {inport_bresp_o, inport_rresp_o, outport_wdata_o[27:0], outport_wstrb_o}, 0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  // AXI4 target model: drives one timestep after the edge, observes on the falling edge.
  initial begin : target
    bit aw_done, w_done, ar_done, b_hs, r_hs;
    int aw_cnt, w_cnt, beat;
    wr_t cw;
    rd_t cr;
    aw_done = 0; w_done = 0; ar_done = 0; b_hs = 0; r_hs = 0;
    aw_cnt = 0; w_cnt = 0; beat = 0;
    cw = mk_wr(0, 0, 0, 0, 0, 0, 0);
    cr = mk_rd(0, 0, 0, 0, 0);
    outport_awready_i = 0; outport_wready_i = 0; outport_bvalid_i = 0; outport_bresp_i = 0;
    outport_bid_i = 0; outport_arready_i = 0; outport_rvalid_i = 0; outport_rdata_i = 0;
    outport_rresp_i = 0; outport_rid_i = 0; outport_rlast_i = 0;
    forever begin
      @(posedge clk_i); #1;
      if (!rst_ni) begin
        aw_done = 0; w_done = 0; ar_done = 0; b_hs = 0; r_hs = 0;
        aw_cnt = 0; w_cnt = 0; beat = 0;
        tgt_w_q.delete(); tgt_r_q.delete();
        outport_awready_i = 0; outport_wready_i = 0; outport_bvalid_i = 0;
        outport_arready_i = 0; outport_rvalid_i = 0; outport_rlast_i = 0;
      end else begin
        if (b_hs) check("b_out_in_1cyc", inport_bvalid_o, 1'b1);
        if (r_hs) check("r_out_in_1cyc", inport_rvalid_o, 1'b1);
        b_hs = 0; r_hs = 0;
        if (tgt_w_q.size() > 0) cw = tgt_w_q[0];
        if (tgt_r_q.size() > 0) cr = tgt_r_q[0];
        outport_awready_i = !aw_done && outport_awvalid_o && (aw_cnt >= cw.aw_dly);
        outport_wready_i  = !w_done && outport_wvalid_o && (w_cnt >= cw.w_dly);
        outport_bvalid_i  = aw_done && w_done;
        outport_bresp_i   = cw.bresp;
        outport_bid_i     = cw.bad_id ? 4'h3 : AXI_ID;
        outport_arready_i = !ar_done && outport_arvalid_o;
        outport_rvalid_i  = ar_done;
        outport_rlast_i   = (beat == cr.n_pre);
        outport_rdata_i   = outport_rlast_i ? cr.data : $urandom;
        outport_rresp_i   = outport_rlast_i ? cr.rresp : 2'($urandom_range(3, 0));
        outport_rid_i     = (outport_rlast_i && cr.bad_id) ? 4'h5 : AXI_ID;
        @(negedge clk_i);
        if (rst_ni) begin
          if (aw_done && !w_done) check("aw_drop_w_hold", {outport_awvalid_o, outport_wvalid_o}, 2'b01);
          if (w_done && !aw_done) check("w_drop_aw_hold", {outport_awvalid_o, outport_wvalid_o}, 2'b10);
          if (outport_awvalid_o) aw_cnt++;
          if (outport_wvalid_o) w_cnt++;
          if (outport_awvalid_o && outport_awready_i) begin
            check("aw_fields", {outport_awaddr_o, outport_awlen_o, outport_awburst_o, outport_awid_o},
                  {cw.addr, 8'd0, 2'b01, AXI_ID});
            check("aw_no_overlap", {ar_done, outport_arvalid_o}, 0);
            aw_done = 1;
          end
          if (outport_wvalid_o && outport_wready_i) begin
            check("w_fields", {outport_wdata_o, outport_wstrb_o, outport_wlast_o}, {cw.data, cw.strb, 1'b1});
            w_done = 1;
          end
          if (outport_bvalid_i && outport_bready_o) begin
            if (tgt_w_q.size() > 0) cw = tgt_w_q.pop_front();
            aw_done = 0; w_done = 0; aw_cnt = 0; w_cnt = 0; b_hs = 1;
          end
          if (outport_arvalid_o && outport_arready_i) begin
            check("ar_fields", {outport_araddr_o, outport_arlen_o, outport_arburst_o, outport_arid_o},
                  {cr.addr, 8'd0, 2'b01, AXI_ID});
            check("ar_no_overlap", {aw_done, w_done, outport_awvalid_o, outport_wvalid_o}, 0);
            ar_done = 1; beat = 0;
          end
          if (outport_rvalid_i && outport_rready_o) begin
            if (outport_rlast_i) begin
              if (tgt_r_q.size() > 0) cr = tgt_r_q.pop_front();
              ar_done = 0; beat = 0; r_hs = 1;
            end else begin
              beat++;
            end
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every Lite response handshake and logs grants.
  initial begin : monitor
    logic [1:0] eb;
    logic [33:0] er;
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        if (inport_awready_o) grant_log.push_back(G_W);
        if (inport_arready_o) grant_log.push_back(G_R);
        if (inport_bvalid_o && inport_bready_i) begin
          if (exp_b_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected actual=%0h required=none", inport_bresp_o);
          end else begin
            eb = exp_b_q.pop_front();
            check("bresp", inport_bresp_o, eb);
          end
        end
        if (inport_rvalid_o && inport_rready_i) begin
          if (exp_r_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL r_unexpected actual=%0h required=none", inport_rdata_o);
          end else begin
            er = exp_r_q.pop_front();
            check("rresp_rdata", {inport_rresp_o, inport_rdata_o}, er);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog actual=running required=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : main
    wr_t w;
    rd_t r;
    byte exp_g[$];
    int nw, nr;
    bit last_w;
    do_reset();

    do_write(mk_wr(32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 2'b00, 0, 0, 0), 0, 1);
    do_read(mk_rd(32'h0000_2004, 32'h1234_5678, 2'b00, 0, 0), 5, 1);
    do_write(mk_wr(32'h0000_1008, 32'h0BAD_F00D, 4'h5, 2'b00, 0, 0, 3), 1, 1);
    do_write(mk_wr(32'h0000_100C, 32'h7777_8888, 4'hC, 2'b00, 1, 1, 0), 2, 1);
    do_read(mk_rd(32'h0000_2010, 32'hCAFE_F00D, 2'b00, 1, 0), 1, 1);
    do_read(mk_rd(32'h0000_2011, 32'h0102_0304, 2'b01, 0, 1), 0, 1);

    // Contention: two writes and two reads offered together from a fresh reset.
    do_reset();
    grant_log.delete();
    fork
      begin
        do_write(mk_wr(32'h4000, 32'hA1, 4'hF, 2'b00, 0, 0, 0), 0, 0);
        do_write(mk_wr(32'h4004, 32'hA2, 4'h1, 2'b11, 0, 0, 0), 0, 0);
      end
      begin
        do_read(mk_rd(32'h5000, 32'hB1, 2'b00, 0, 0), 0, 0);
        do_read(mk_rd(32'h5004, 32'hB2, 2'b10, 0, 0), 0, 0);
      end
    join
    nw = 2; nr = 2; last_w = 0;
    while (nw > 0 || nr > 0) begin
      if (nw > 0 && (nr == 0 || !last_w)) begin exp_g.push_back(G_W); nw--; last_w = 1; end
      else begin exp_g.push_back(G_R); nr--; last_w = 0; end
    end
    check("grant_count", grant_log.size(), exp_g.size());
    for (int i = 0; i < exp_g.size() && i < grant_log.size(); i++)
      check("grant_order", grant_log[i], exp_g[i]);

    // Reset while the write request is still waiting on the target.
    do_reset();
    w = mk_wr(32'h3000, 32'h1111_2222, 4'h3, 2'b00, 0, 1000, 1000);
    tgt_w_q.push_back(w);
    inport_awaddr_i = w.addr; inport_wdata_i = w.data; inport_wstrb_i = w.strb;
    inport_awvalid_i = 1'b1; inport_wvalid_i = 1'b1;
    @(negedge clk_i);
    check("rst_mid_accept", {inport_awready_o, inport_wready_o}, 2'b11);
    @(posedge clk_i); #1;
    inport_awvalid_i = 1'b0; inport_wvalid_i = 1'b0;
    @(posedge clk_i); #1;
    check("rst_mid_in_wr_req", {outport_awvalid_o, outport_wvalid_o}, 2'b11);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_mid_valids_drop", {outport_awvalid_o, outport_wvalid_o, outport_arvalid_o,
          outport_bready_o, outport_rready_o, inport_bvalid_o, inport_rvalid_o}, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    do_read(mk_rd(32'h0000_2008, 32'hA5A5_0F0F, 2'b00, 0, 0), 1, 1);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        w = mk_wr($urandom, $urandom, 4'($urandom_range(15, 0)), 2'($urandom_range(3, 0)),
                  ($urandom_range(3, 0) == 0), $urandom_range(3, 0), $urandom_range(3, 0));
        do_write(w, $urandom_range(3, 0), 1);
      end else begin
        r = mk_rd($urandom, $urandom, 2'($urandom_range(3, 0)),
                  ($urandom_range(3, 0) == 0) ? $urandom_range(2, 1) : 0, ($urandom_range(3, 0) == 0));
        do_read(r, $urandom_range(3, 0), 1);
      end
    end

    repeat (3) @(posedge clk_i);
    check("scoreboard_drained", {exp_b_q.size() == 0, exp_r_q.size() == 0}, 2'b11);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
